// File: rtl/vtb_pkg.sv
// rtl/vtb_pkg.sv - shared types and sizing helpers for vector_tile_buffer
package vtb_pkg;

  typedef enum logic [1:0] {IDLE, FILLING, COMMIT} state_t;

  // One tile element at the default 8-bit element width.
  typedef logic [7:0] tile_t;

  function automatic int elem_count(input int tile_width, input int data_width);
    return tile_width / data_width;
  endfunction

  function automatic int count_width(input int tiles);
    return $clog2(tiles) + 1;
  endfunction

endpackage

// File: rtl/vtb_bank.sv
// rtl/vtb_bank.sv - one tile-wide 1R1W synchronous RAM; reads return pre-write contents
module vtb_bank #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/vector_tile_buffer.sv
// rtl/vector_tile_buffer.sv - ping-pong tile buffer with fill FSM; VECTOR_TILE_BUFFER_OVF_CHECK_EN drops tiles past capacity
module vector_tile_buffer
  import vtb_pkg::*;
#(
  parameter int TILE_WIDTH    = 256,
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_BUFS      = 2,
  parameter int TILES_PER_BUF = 32,
  localparam int ELEM_COUNT = elem_count(TILE_WIDTH, DATA_WIDTH),
  localparam int BID_W      = $clog2(NUM_BUFS),
  localparam int IDX_W      = $clog2(TILES_PER_BUF),
  localparam int CNT_W      = count_width(TILES_PER_BUF)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_start,
  input  logic [BID_W-1:0]      wr_buf_id,
  input  logic                  tile_in,
  input  logic [DATA_WIDTH-1:0] tile_data [ELEM_COUNT],
  input  logic                  load_done,
  input  logic                  rd_en,
  input  logic [BID_W-1:0]      rd_buf_id,
  input  logic [IDX_W-1:0]      rd_tile_idx,
  output logic [DATA_WIDTH-1:0] rd_data [ELEM_COUNT],
  output logic                  rd_valid,
  output logic [NUM_BUFS-1:0]   buf_ready,
  output logic [CNT_W-1:0]      fill_count,
  output logic                  busy,
  output logic                  overflow
);

  state_t               state;
  logic [BID_W-1:0]     cur_buf;
  logic [BID_W-1:0]     rd_sel;
  logic [CNT_W-1:0]     wr_ptr;
  logic [TILE_WIDTH-1:0] wr_word;
  logic [TILE_WIDTH-1:0] bank_q [NUM_BUFS];
  logic                 room;
  logic                 wr_en;

  always_comb begin
    wr_word = '0;
    for (int i = 0; i < ELEM_COUNT; i++) wr_word[i*DATA_WIDTH +: DATA_WIDTH] = tile_data[i];
  end

`ifdef VECTOR_TILE_BUFFER_OVF_CHECK_EN
  assign room = (wr_ptr != CNT_W'(TILES_PER_BUF));
`else
  assign room = 1'b1;
`endif

  assign wr_en = (state == FILLING) && tile_in && room;

  for (genvar b = 0; b < NUM_BUFS; b++) begin : g_bank
    vtb_bank #(.WIDTH(TILE_WIDTH), .DEPTH(TILES_PER_BUF)) u_bank (
      .clk   (clk),
      .we    (wr_en && (cur_buf == BID_W'(b))),
      .waddr (wr_ptr[IDX_W-1:0]),
      .wdata (wr_word),
      .re    (rd_en && (rd_buf_id == BID_W'(b))),
      .raddr (rd_tile_idx),
      .rdata (bank_q[b])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_sel   <= '0;
    end else begin
      rd_valid <= rd_en;
      rd_sel   <= rd_buf_id;
    end
  end

  // Gating on rd_valid keeps rd_data at zero through and after reset.
  always_comb begin
    for (int i = 0; i < ELEM_COUNT; i++)
      rd_data[i] = rd_valid ? bank_q[rd_sel][i*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cur_buf    <= '0;
      wr_ptr     <= '0;
      fill_count <= '0;
      buf_ready  <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (wr_start) begin
          cur_buf              <= wr_buf_id;
          buf_ready[wr_buf_id] <= 1'b0;
          wr_ptr               <= '0;
          fill_count           <= '0;
          busy                 <= 1'b1;
          state                <= FILLING;
        end
        FILLING: begin
          if (wr_en) begin
`ifdef VECTOR_TILE_BUFFER_OVF_CHECK_EN
            wr_ptr <= wr_ptr + CNT_W'(1);
`else
            wr_ptr <= (wr_ptr == CNT_W'(TILES_PER_BUF - 1)) ? '0 : wr_ptr + CNT_W'(1);
`endif
            if (fill_count != CNT_W'(TILES_PER_BUF)) fill_count <= fill_count + CNT_W'(1);
          end
          if (load_done) state <= COMMIT;
        end
        COMMIT: begin
          buf_ready[cur_buf] <= 1'b1;
          busy               <= 1'b0;
          state              <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VECTOR_TILE_BUFFER_OVF_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow <= 1'b0;
    else if (state == IDLE && wr_start) overflow <= 1'b0;
    else if (state == FILLING && tile_in && !room) overflow <= 1'b1;
  end
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_vector_tile_buffer.sv
// tb/tb_vector_tile_buffer.sv - self-checking bench for vector_tile_buffer
module tb_vector_tile_buffer;
  import vtb_pkg::*;

  localparam int EC = 32;
  localparam int TW = 256;
  localparam int NB = 2;
  localparam int TP = 32;
`ifdef VECTOR_TILE_BUFFER_OVF_CHECK_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_start = 1'b0;
  logic [0:0] wr_buf_id = '0;
  logic       tile_in = 1'b0;
  tile_t      tile_data [EC];
  logic       load_done = 1'b0;
  logic       rd_en = 1'b0;
  logic [0:0] rd_buf_id = '0;
  logic [4:0] rd_tile_idx = '0;
  tile_t      rd_data [EC];
  logic       rd_valid;
  logic [1:0] buf_ready;
  logic [5:0] fill_count;
  logic       busy;
  logic       overflow;

  always #5 clk = ~clk;

  vector_tile_buffer dut (
    .clk(clk), .rst_n(rst_n), .wr_start(wr_start), .wr_buf_id(wr_buf_id),
    .tile_in(tile_in), .tile_data(tile_data), .load_done(load_done),
    .rd_en(rd_en), .rd_buf_id(rd_buf_id), .rd_tile_idx(rd_tile_idx),
    .rd_data(rd_data), .rd_valid(rd_valid), .buf_ready(buf_ready),
    .fill_count(fill_count), .busy(busy), .overflow(overflow)
  );

  logic [TW-1:0] rd_packed;
  logic [TW-1:0] cur_tile;
  always_comb begin
    rd_packed = '0;
    for (int i = 0; i < EC; i++) rd_packed[i*8 +: 8] = rd_data[i];
  end

  int checks = 0;
  int errors = 0;

  // Reference model: buffers as plain arrays, fill progress as counts.
  logic [TW-1:0] m_mem [NB][TP];
  bit            m_known [NB][TP];
  int            m_phase;   // 0 waiting, 1 filling, 2 committing
  int            m_tgt, m_ptr, m_count;
  bit            m_ovf;
  bit [1:0]      m_ready;

  task automatic check(input string nm, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_tgt = 0; m_ptr = 0; m_count = 0; m_ovf = 0; m_ready = '0;
  endtask

  function automatic logic [TW-1:0] rnd_tile();
    logic [TW-1:0] r;
    for (int i = 0; i < TW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    bit            exp_rv, exp_known;
    logic [TW-1:0] exp_rd;
    exp_rv    = rd_en;
    exp_known = rd_en && m_known[rd_buf_id][rd_tile_idx];
    exp_rd    = m_mem[rd_buf_id][rd_tile_idx];
    @(posedge clk); #1;
    case (m_phase)
      0: if (wr_start) begin
        m_tgt = int'(wr_buf_id); m_ready[m_tgt] = 1'b0;
        m_count = 0; m_ptr = 0; m_ovf = 0; m_phase = 1;
      end
      1: begin
        if (tile_in) begin
          if (OVF_EN && m_ptr == TP) m_ovf = 1;
          else begin
            m_mem[m_tgt][m_ptr] = cur_tile;
            m_known[m_tgt][m_ptr] = 1;
            m_ptr = m_ptr + 1;
            if (!OVF_EN && m_ptr == TP) m_ptr = 0;
            if (m_count < TP) m_count = m_count + 1;
          end
        end
        if (load_done) m_phase = 2;
      end
      default: begin
        m_ready[m_tgt] = 1'b1; m_phase = 0;
      end
    endcase
    check("rd_valid", rd_valid, exp_rv);
    if (exp_known) check("rd_data", rd_packed, exp_rd);
    check("buf_ready", buf_ready, m_ready);
    check("fill_count", fill_count, m_count);
    check("busy", busy, m_phase != 0);
    check("overflow", overflow, m_ovf);
  endtask

  task automatic cyc(input bit ws, input int bid, input bit ti, input logic [TW-1:0] tile,
                     input bit ld, input bit re, input int rb, input int ri);
    wr_start = ws; wr_buf_id = 1'(bid); tile_in = ti; load_done = ld;
    rd_en = re; rd_buf_id = 1'(rb); rd_tile_idx = 5'(ri);
    cur_tile = tile;
    for (int i = 0; i < EC; i++) tile_data[i] = tile[i*8 +: 8];
    tick();
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_rd_valid"}, rd_valid, 0);
    check({nm, "_rd_data"}, rd_packed, 0);
    check({nm, "_buf_ready"}, buf_ready, 0);
    check({nm, "_fill_count"}, fill_count, 0);
    check({nm, "_busy"}, busy, 0);
    check({nm, "_overflow"}, overflow, 0);
  endtask

  typedef struct {
    bit ws; int bid; bit ti; logic [7:0] b; bit ld; bit re; int rb; int ri;
    logic [1:0] e_ready; int e_count; bit e_busy; bit e_rv; logic [7:0] e_byte;
  } vec_t;
  vec_t tbl [9];

  logic [TW-1:0] t_first, t_last;

  initial begin
    tbl[0] = '{1, 0, 0, 8'h00, 0, 0, 0, 0, 2'b00, 0, 1, 0, 8'h00};
    tbl[1] = '{0, 0, 1, 8'h11, 0, 0, 0, 0, 2'b00, 1, 1, 0, 8'h00};
    tbl[2] = '{0, 0, 1, 8'h22, 0, 0, 0, 0, 2'b00, 2, 1, 0, 8'h00};
    tbl[3] = '{0, 0, 1, 8'h33, 0, 0, 0, 0, 2'b00, 3, 1, 0, 8'h00};
    tbl[4] = '{0, 0, 0, 8'h00, 1, 0, 0, 0, 2'b00, 3, 1, 0, 8'h00};
    tbl[5] = '{0, 0, 0, 8'h00, 0, 1, 0, 0, 2'b01, 3, 0, 1, 8'h11};
    tbl[6] = '{0, 0, 0, 8'h00, 0, 1, 0, 1, 2'b01, 3, 0, 1, 8'h22};
    tbl[7] = '{0, 0, 0, 8'h00, 0, 1, 0, 2, 2'b01, 3, 0, 1, 8'h33};
    tbl[8] = '{0, 0, 0, 8'h00, 0, 0, 0, 0, 2'b01, 3, 0, 0, 8'h00};

    for (int i = 0; i < EC; i++) tile_data[i] = '0;
    cur_tile = '0;
    for (int b = 0; b < NB; b++) for (int t = 0; t < TP; t++) begin
      m_known[b][t] = 0; m_mem[b][t] = '0;
    end
    model_reset();

    #2 check_reset_outputs("reset");
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic three-tile fill of buffer 0 and read-back.
    for (int k = 0; k < 9; k++) begin
      cyc(tbl[k].ws, tbl[k].bid, tbl[k].ti, {EC{tbl[k].b}}, tbl[k].ld, tbl[k].re, tbl[k].rb, tbl[k].ri);
      check($sformatf("tbl%0d_ready", k), buf_ready, tbl[k].e_ready);
      check($sformatf("tbl%0d_count", k), fill_count, tbl[k].e_count);
      check($sformatf("tbl%0d_busy", k), busy, tbl[k].e_busy);
      check($sformatf("tbl%0d_rv", k), rd_valid, tbl[k].e_rv);
      if (tbl[k].e_rv) check($sformatf("tbl%0d_data", k), rd_packed, {EC{tbl[k].e_byte}});
    end

    // Last tile coincides with load_done.
    cyc(1, 0, 0, '0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) cyc(0, 0, 1, {EC{8'(8'h41 + k)}}, k == 3, 0, 0, 0);
    check("coinc_count", fill_count, 4);
    cyc(0, 0, 0, '0, 0, 0, 0, 0);
    cyc(0, 0, 0, '0, 0, 1, 0, 3);
    check("coinc_tile3", rd_packed, {EC{8'h44}});
    check("coinc_ready", buf_ready[0], 1);

    // Same-cycle write and read of buffer 0 index 5 returns old data.
    cyc(1, 0, 0, '0, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) cyc(0, 0, 1, {EC{(k == 5) ? 8'hAA : 8'(k)}}, k == 5, 0, 0, 0);
    cyc(0, 0, 0, '0, 0, 0, 0, 0);
    cyc(1, 0, 0, '0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) cyc(0, 0, 1, {EC{8'(k + 1)}}, 0, 0, 0, 0);
    cyc(0, 0, 1, {EC{8'h55}}, 0, 1, 0, 5);
    check("rw_old", rd_packed, {EC{8'hAA}});
    cyc(0, 0, 0, '0, 1, 1, 0, 5);
    check("rw_new", rd_packed, {EC{8'h55}});
    cyc(0, 0, 0, '0, 0, 0, 0, 0);

    // Fill buffer 1 while reading buffer 0 every cycle.
    cyc(1, 1, 0, '0, 0, 1, 0, 0);
    for (int k = 0; k < 10; k++) begin
      cyc(0, 0, 1, rnd_tile(), k == 9, 1, 0, $urandom_range(0, 5));
      check("pp_ready0", buf_ready[0], 1);
    end
    cyc(0, 0, 0, '0, 0, 1, 0, 1);
    check("pp_ready_both", buf_ready, 2'b11);

    // 33 tiles into a 32-deep buffer.
    cyc(1, 1, 0, '0, 0, 0, 0, 0);
    for (int k = 0; k < 33; k++) begin
      cur_tile = rnd_tile();
      if (k == 0) t_first = cur_tile;
      if (k == 32) t_last = cur_tile;
      cyc(0, 0, 1, cur_tile, 0, 0, 0, 0);
    end
    check("ovf_count", fill_count, 32);
    check("ovf_flag", overflow, OVF_EN);
    cyc(0, 0, 0, '0, 1, 1, 1, 0);
    check("ovf_idx0", rd_packed, OVF_EN ? t_first : t_last);
    cyc(0, 0, 0, '0, 0, 0, 0, 0);
    check("ovf_sticky", overflow, OVF_EN);
    cyc(1, 1, 0, '0, 0, 0, 0, 0);
    check("ovf_clear", overflow, 0);
    cyc(0, 0, 0, '0, 1, 0, 0, 0);
    cyc(0, 0, 0, '0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of a fill.
    cyc(1, 0, 0, '0, 0, 0, 0, 0);
    cyc(0, 0, 1, rnd_tile(), 0, 0, 0, 0);
    cyc(0, 0, 1, rnd_tile(), 0, 1, 1, 3);
    wr_start = 0; tile_in = 0; load_done = 0; rd_en = 0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midfill_reset");
    model_reset();
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    cyc(0, 0, 0, '0, 0, 0, 0, 0);
    check("post_reset_ready", buf_ready, 0);
    cyc(1, 0, 0, '0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) cyc(0, 0, 1, rnd_tile(), k == 2, 0, 0, 0);
    cyc(0, 0, 0, '0, 0, 1, 0, 2);
    check("refill_ready", buf_ready, 2'b01);
    check("refill_count", fill_count, 3);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++)
      cyc($urandom_range(0, 19) == 0, $urandom_range(0, 1), $urandom_range(0, 1), rnd_tile(),
          $urandom_range(0, 11) == 0, $urandom_range(0, 9) < 6, $urandom_range(0, 1),
          $urandom_range(0, TP - 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_tile_buffer.md
VECTOR_TILE_BUFFER -- requirements
Module: vector_tile_buffer

Interface
REQ-001 SHALL have parameter TILE_WIDTH, default 256, meaning bits per tile; must be a multiple of DATA_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning bits per element; ELEM_COUNT = TILE_WIDTH/DATA_WIDTH.
REQ-003 SHALL have parameter NUM_BUFS, default 2, meaning number of independent tile buffers (ping-pong).
REQ-004 SHALL have parameter TILES_PER_BUF, default 32, meaning tile capacity of each buffer.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-007 SHALL have port wr_start, input, 1, meaning begin a new fill of buffer wr_buf_id.
REQ-008 SHALL have port wr_buf_id, input, clog2(NUM_BUFS), meaning the target buffer, sampled with wr_start.
REQ-009 SHALL have port tile_in, input, 1, a one-cycle pulse meaning tile_data holds one complete tile.
REQ-010 SHALL have port tile_data, input, ELEM_COUNT x DATA_WIDTH unpacked array, meaning element i of the incoming tile.
REQ-011 SHALL have port load_done, input, 1, a one-cycle pulse meaning the upstream transfer has ended.
REQ-012 SHALL have ports rd_en (input, 1), rd_buf_id (input, clog2(NUM_BUFS)) and rd_tile_idx (input, clog2(TILES_PER_BUF)), meaning a tile read request.
REQ-013 SHALL have ports rd_data (output, ELEM_COUNT x DATA_WIDTH) and rd_valid (output, 1), meaning read response.
REQ-014 SHALL have port buf_ready, output, NUM_BUFS, meaning per-buffer "filled and committed" flag.
REQ-015 SHALL have ports fill_count (output, clog2(TILES_PER_BUF)+1), busy (output, 1) and overflow (output, 1).

Function
REQ-016 SHALL implement FSM states IDLE, FILLING, COMMIT; busy = 1 in FILLING and COMMIT.
REQ-017 IDLE: on wr_start SHALL latch wr_buf_id, clear buf_ready[wr_buf_id], zero wr_ptr and fill_count, and go to FILLING next cycle.
REQ-018 FILLING: each tile_in SHALL write tile_data to the selected buffer at wr_ptr, then increment wr_ptr and fill_count.
REQ-019 FILLING: load_done SHALL move to COMMIT; when tile_in and load_done coincide, the tile SHALL be written first and counted.
REQ-020 COMMIT: SHALL set buf_ready for the latched buffer for one cycle's transition, then return to IDLE; total FILLING-exit to IDLE is 1 cycle.
REQ-021 tile_in or load_done in IDLE or COMMIT SHALL be ignored; wr_start outside IDLE SHALL be ignored.
REQ-022 Read: rd_en SHALL produce rd_data and rd_valid = 1 exactly one cycle later; rd_valid = 0 otherwise; reads are legal in any state and for any buffer.
REQ-023 Read and write to the same buffer and index in the same cycle SHALL return the old contents.
REQ-024 Buffer contents SHALL be unaffected by wr_start; locations not written in a fill retain stale data.
REQ-025 Writes to buffer A SHALL never alter buf_ready or contents of buffer B.

Reset
REQ-026 On rst_n low, asynchronously: state = IDLE, wr_ptr = 0, fill_count = 0, buf_ready = 0, busy = 0, overflow = 0, rd_valid = 0, rd_data = 0.
REQ-027 Reset mid-fill SHALL abandon the fill with no buf_ready set; RAM contents are not cleared.

Configuration
REQ-028 Macro VECTOR_TILE_BUFFER_OVF_CHECK_EN: when defined, a tile_in with wr_ptr = TILES_PER_BUF SHALL be dropped, fill_count held, and overflow set sticky until next accepted wr_start.
REQ-029 When VECTOR_TILE_BUFFER_OVF_CHECK_EN is undefined, wr_ptr SHALL wrap to 0 and overwrite, fill_count saturates at TILES_PER_BUF, and overflow is tied to 0.

Structure
REQ-030 Package vtb_pkg SHALL hold ELEM_COUNT computation helpers, tile_t element typedef, and the FSM state enum.
REQ-031 One sub-module vtb_bank SHALL implement a single tile-wide 1R1W synchronous RAM of TILES_PER_BUF entries, instantiated NUM_BUFS times.

Verification
REQ-032 wr_start(buf 0), 3 tile_in pulses with elements 0x11/0x22/0x33, load_done -> buf_ready[0] = 1, fill_count = 3, reads idx 0..2 return those tiles one cycle after rd_en.
REQ-033 Final tile_in and load_done in same cycle after 4 tiles -> fill_count = 4, tile 3 readable, buf_ready[0] = 1.
REQ-034 Fill buf 1 while reading buf 0 every cycle -> buf 0 data unchanged, buf_ready[0] stays 1, buf_ready[1] set at end.
REQ-035 Same-cycle write and read of buf 0 idx 5 (old 0xAA, new 0x55) -> rd_data = 0xAA; next read = 0x55.
REQ-036 33 tiles into TILES_PER_BUF = 32 -> with macro: overflow = 1, fill_count = 32, idx 0 intact; without: idx 0 holds tile 33, overflow = 0.
REQ-037 rst_n low after 2 tiles -> all outputs at reset values asynchronously, buf_ready stays 0, next wr_start fills normally.
